// File: rtl/cpu_defines.sv
// Shared CPU definitions used by the execute-stage divider: state encodings,
// datapath width and the fixed divide-by-zero result.
package cpu_defines;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Divide by zero never traps; LO reads all ones and HI returns the dividend.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor and keep or restore the partial remainder.
module div_step
    import cpu_defines::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor holds between steps, so bit WIDTH of diff is a true sign bit.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            next_rem = diff[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            next_rem = shifted[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Execute-stage multi-cycle radix-2 restoring divider for DIV/DIVU. Holds the
// pipeline through div_stall and presents HI/LO results while div_valid is high.
module div_unit
    import cpu_defines::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    input  logic             stage_ena,
    output logic             div_stall,
    output logic             div_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             start_ok;
    logic             dvs_zero;
    logic             last_iter;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                    input logic             neg);
        return neg ? -m : m;
    endfunction

    assign start_ok  = div_start && !cancel;
    assign dvs_zero  = (divisor == '0);
    assign last_iter = (cnt == CNT_W'(1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start_ok) state_nxt = dvs_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (cancel)         state_nxt = DIV_IDLE;
                else if (last_iter) state_nxt = DIV_DONE;
            end
            // A held instruction waits here; only advancing or a flush releases it.
            DIV_DONE: if (cancel || stage_ena) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        div_stall = ((state == DIV_IDLE) && start_ok) || (state == DIV_BUSY);
        div_valid = (state == DIV_DONE);
    end

    // Iteration datapath: operands are reduced to magnitudes at start.
    always_ff @(posedge clk) begin
        if ((state == DIV_IDLE) && start_ok) begin
            quo_r <= magnitude(dividend, div_signed);
            dvs_r <= magnitude(divisor, div_signed);
            rem_r <= '0;
            q_neg <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= div_signed && dividend[WIDTH-1];
        end else if (state == DIV_BUSY) begin
            quo_r <= step_quo;
            rem_r <= step_rem;
        end
    end

    // Result registers are loaded once on entry to DONE and held there.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            res_quo <= '0;
            res_rem <= '0;
        end else if ((state == DIV_IDLE) && start_ok) begin
            cnt <= CNT_W'(WIDTH);
            if (dvs_zero) begin
                res_quo <= DIV0_QUO;
                res_rem <= dividend;
            end
        end else if (state == DIV_BUSY) begin
            cnt <= cnt - CNT_W'(1);
            if (last_iter && !cancel) begin
                res_quo <= apply_sign(step_quo, q_neg);
                res_rem <= apply_sign(step_rem, r_neg);
            end
        end
    end

    assign quotient  = res_quo;
    assign remainder = res_rem;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, hand-written cancel/reset
// sequences and random operands against an arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         div_start;
    logic         div_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         cancel;
    logic         stage_ena;
    logic         div_stall;
    logic         div_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        tag;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .stage_ena  (stage_ena),
        .div_stall  (div_stall),
        .div_valid  (div_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // MIPS semantics from plain 64-bit arithmetic: truncating division,
    // remainder follows the dividend, overflow wraps, x/0 gives ~0 r x.
    task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called shortly after a rising edge with the unit idle.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input int hold);
        int stalls;
        int cyc;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        cancel     = 1'b0;
        stage_ena  = (hold == 0);
        stalls     = 0;
        cyc        = 0;
        #1;
        while (!div_valid && cyc < 100) begin
            if (div_stall) stalls++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " valid"}, div_valid, 1);
        check({tag, " stall_cycles"}, stalls, (b == 0) ? 1 : 33);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " stall_in_done"}, div_stall, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, div_valid, 1);
            check({tag, " hold stall"}, div_stall, 0);
            check({tag, " hold quotient"}, quotient, eq);
            check({tag, " hold remainder"}, remainder, er);
        end
        stage_ena = 1'b1;
        div_start = 1'b0;
        @(posedge clk); #1;
        check({tag, " idle valid"}, div_valid, 0);
        check({tag, " idle stall"}, div_stall, 0);
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           seen;

        rst        = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        cancel     = 1'b0;
        stage_ena  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset stall", div_stall, 0);
        check("reset valid", div_valid, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs.push_back('{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          0});
        vecs.push_back('{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0});
        vecs.push_back('{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0});
        vecs.push_back('{"div_overflow", 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0});
        vecs.push_back('{"divu_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          0});
        vecs.push_back('{"div_m5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  0});
        vecs.push_back('{"divu_hold",    1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          4});
        vecs.push_back('{"divu_big",     1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  0});
        vecs.push_back('{"divu_20_3",    1'b0, 32'd20,         32'd3,          32'd6,          32'd2,          0});
        vecs.push_back('{"divu_20_6",    1'b0, 32'd20,         32'd6,          32'd3,          32'd2,          0});

        foreach (vecs[i])
            run_div(vecs[i].tag, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].hold);

        // Flush during iteration 10 of a divide.
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd7;
        div_start  = 1'b1;
        stage_ena  = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        #1;
        check("cancel cycle stall", div_stall, 1);
        @(posedge clk); #1;
        cancel    = 1'b0;
        div_start = 1'b0;
        #1;
        check("after cancel stall", div_stall, 0);
        check("after cancel valid", div_valid, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_valid || div_stall) seen++;
        end
        check("cancel no restart", seen, 0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

        // Reset in the middle of a divide.
        dividend  = 32'd1000;
        divisor   = 32'd7;
        div_start = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        rst       = 1'b1;
        div_start = 1'b0;
        @(posedge clk); #1;
        check("mid reset stall", div_stall, 0);
        check("mid reset valid", div_valid, 0);
        check("mid reset quotient", quotient, 0);
        check("mid reset remainder", remainder, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 15));
                3, 4:    rb = -W'($urandom_range(1, 15));
                5:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            ref_div(rs, ra, rb, eq, er);
            run_div("random", rs, ra, rb, eq, er, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
